// File: rtl/rotor_stepper.sv
// Enigma rotor position controller: odometer stepping with the middle-rotor double step.
// Optional key debounce enabled by defining ROTOR_STEPPER_DEBOUNCE_EN.
module rotor_stepper #(
    parameter logic [5:0] R_NOTCH         = 6'd21,
    parameter logic [5:0] M_NOTCH         = 6'd4,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [5:0]  pos_r_in,
    input  logic [5:0]  pos_m_in,
    input  logic [5:0]  pos_l_in,
    input  logic        key_press,
    output logic [5:0]  shift_r,
    output logic [5:0]  shift_m,
    output logic [5:0]  shift_l,
    output logic        busy,
    output logic        shift_valid,
    output logic [15:0] key_count
);

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  pos_r_q, pos_r_d, pos_m_q, pos_m_d, pos_l_q, pos_l_d;
    logic [15:0] key_count_q, key_count_d;
    logic        key_q;
    logic        key_lvl;
    logic        key_edge;

    function automatic logic [5:0] wrap_inc(input logic [5:0] p);
        return (p == 6'd25) ? 6'd0 : p + 6'd1;
    endfunction

    function automatic logic [5:0] clamp_pos(input logic [5:0] p);
        return (p >= 6'd26) ? 6'd0 : p;
    endfunction

`ifdef ROTOR_STEPPER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q, deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised input disagrees with the debounced level.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_press;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_lvl = deb_q;
`else
    assign key_lvl = key_press;
`endif

    assign key_edge = key_lvl & ~key_q;

    // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        pos_r_d     = pos_r_q;
        pos_m_d     = pos_m_q;
        pos_l_d     = pos_l_q;
        key_count_d = key_count_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    pos_r_d     = clamp_pos(pos_r_in);
                    pos_m_d     = clamp_pos(pos_m_in);
                    pos_l_d     = clamp_pos(pos_l_in);
                    key_count_d = 16'd0;
                end else if (key_edge) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                // Middle notch steps both middle and left: the double step.
                pos_r_d = wrap_inc(pos_r_q);
                if (pos_r_q == R_NOTCH || pos_m_q == M_NOTCH) pos_m_d = wrap_inc(pos_m_q);
                if (pos_m_q == M_NOTCH) pos_l_d = wrap_inc(pos_l_q);
                key_count_d = key_count_q + 16'd1;
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pos_r_q     <= 6'd0;
            pos_m_q     <= 6'd0;
            pos_l_q     <= 6'd0;
            key_count_q <= 16'd0;
            key_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_r_q     <= pos_r_d;
            pos_m_q     <= pos_m_d;
            pos_l_q     <= pos_l_d;
            key_count_q <= key_count_d;
            key_q       <= key_lvl;
        end
    end

    assign shift_r     = pos_r_q;
    assign shift_m     = pos_m_q;
    assign shift_l     = pos_l_q;
    assign busy        = (state_q != IDLE);
    assign shift_valid = (state_q == DONE);
    assign key_count   = key_count_q;

endmodule
